// File: rtl/ram_w_burst_if.sv
// ram_w_burst_if: burst write port between ram_w_burst and a RAM slave.
// Signals: ram_w_address/ram_w_burstcount/ram_w_write/ram_w_writedata/ram_w_byteenable driven by the master,
// ram_w_waitrequest driven by the slave to stall the current beat.
interface ram_w_burst_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADD_WIDTH = 32,
  parameter int BURST_WIDTH_W = 6
);
  logic [ADD_WIDTH-1:0] ram_w_address;
  logic ram_w_waitrequest;
  logic [DATA_WIDTH/8-1:0] ram_w_byteenable;
  logic ram_w_write;
  logic [DATA_WIDTH-1:0] ram_w_writedata;
  logic [BURST_WIDTH_W-1:0] ram_w_burstcount;
  modport master (
    output ram_w_address, ram_w_byteenable, ram_w_write, ram_w_writedata, ram_w_burstcount,
    input ram_w_waitrequest
  );
  modport slave (
    input ram_w_address, ram_w_byteenable, ram_w_write, ram_w_writedata, ram_w_burstcount,
    output ram_w_waitrequest
  );
endinterface

// File: rtl/ram_w_burst.sv
// ram_w_burst: buffers pushed words in a show-ahead FIFO and drains a job of n words as bursts to a RAM write port.
// Ports: clk; rst (asynchronous, active-low); bus (ram_w_burst_if.master) burst write port;
// data_fifo_out/data_valid_fifo_out push words; start_fifo_out/address_fifo_out/n_words_fifo_out start (and flush) a job;
// bussy_fifo_out job active, full_fifo_out/usedw_fifo_out buffer status, done_fifo_out one-cycle job-complete pulse.
// Define RAM_W_PARTIAL_BURST_EN to allow a shortened final burst; otherwise job length rounds down to whole bursts.
module ram_w_burst #(
  parameter int DATA_WIDTH = 32,
  parameter int ADD_WIDTH = 32,
  parameter int BYTE_ENABLE_WIDTH = DATA_WIDTH / 8,
  parameter int MAX_BURST_COUNT_W = 32,
  parameter int BURST_WIDTH_W = 6,
  parameter int FIFO_DEPTH_LOG2 = 8,
  parameter int LEN_WIDTH = 24
) (
  input  logic clk,
  input  logic rst,
  ram_w_burst_if.master bus,
  input  logic [DATA_WIDTH-1:0] data_fifo_out,
  input  logic data_valid_fifo_out,
  input  logic start_fifo_out,
  input  logic [ADD_WIDTH-1:0] address_fifo_out,
  input  logic [LEN_WIDTH-1:0] n_words_fifo_out,
  output logic bussy_fifo_out,
  output logic full_fifo_out,
  output logic [FIFO_DEPTH_LOG2:0] usedw_fifo_out,
  output logic done_fifo_out
);
  typedef enum logic [1:0] {IDLE, WAIT_DATA, BURST} state_t;
  localparam logic [FIFO_DEPTH_LOG2:0] DEPTH = {1'b1, {FIFO_DEPTH_LOG2{1'b0}}};
  localparam logic [LEN_WIDTH-1:0] MAX_LEN = LEN_WIDTH'(MAX_BURST_COUNT_W);
  localparam logic [LEN_WIDTH-1:0] ONE = LEN_WIDTH'(1);
  localparam int BE_SHIFT = $clog2(BYTE_ENABLE_WIDTH);
  logic [DATA_WIDTH-1:0] mem [2**FIFO_DEPTH_LOG2];
  logic [FIFO_DEPTH_LOG2-1:0] rd_ptr, wr_ptr;
  logic [FIFO_DEPTH_LOG2:0] count;
  state_t state, state_n;
  logic [ADD_WIDTH-1:0] addr, addr_n;
  logic [LEN_WIDTH-1:0] rem, rem_n, load_len, occ;
  logic [BURST_WIDTH_W-1:0] bc, bc_n, beat, beat_n, cur_len, nxt_len;
  logic wr, wr_n, done, done_n, pop, push;

  function automatic logic [BURST_WIDTH_W-1:0] len_of(input logic [LEN_WIDTH-1:0] r);
    return BURST_WIDTH_W'(r < MAX_LEN ? r : MAX_LEN);
  endfunction

`ifdef RAM_W_PARTIAL_BURST_EN
  assign load_len = n_words_fifo_out;
`else
  assign load_len = n_words_fifo_out & ~(MAX_LEN - ONE);
`endif

  assign occ = LEN_WIDTH'(count);
  assign pop = wr && !bus.ram_w_waitrequest;
  // a full buffer still takes a word when the head leaves in the same cycle
  assign push = data_valid_fifo_out && !start_fifo_out && (count != DEPTH || pop);
  assign cur_len = len_of(rem);
  assign nxt_len = len_of(rem - ONE);
  assign bus.ram_w_address = addr;
  assign bus.ram_w_burstcount = bc;
  assign bus.ram_w_write = wr;
  assign bus.ram_w_writedata = mem[rd_ptr];
  assign bus.ram_w_byteenable = '1;
  assign bussy_fifo_out = rem != '0;
  assign full_fifo_out = count == DEPTH;
  assign usedw_fifo_out = count;
  assign done_fifo_out = done;

  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= data_fifo_out;

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else if (start_fifo_out) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{FIFO_DEPTH_LOG2{1'b0}}, push} - {{FIFO_DEPTH_LOG2{1'b0}}, pop};
    end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      addr <= '0;
      rem <= '0;
      bc <= '0;
      beat <= '0;
      wr <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      addr <= addr_n;
      rem <= rem_n;
      bc <= bc_n;
      beat <= beat_n;
      wr <= wr_n;
      done <= done_n;
    end

  always_comb begin
    state_n = state;
    addr_n = addr;
    rem_n = rem;
    bc_n = bc;
    beat_n = beat;
    wr_n = wr;
    done_n = 1'b0;
    if (start_fifo_out) begin
      addr_n = address_fifo_out;
      rem_n = load_len;
      wr_n = 1'b0;
      state_n = load_len != '0 ? WAIT_DATA : IDLE;
      done_n = load_len == '0;
    end else case (state)
      WAIT_DATA:
        if (occ >= LEN_WIDTH'(cur_len)) begin
          bc_n = cur_len;
          beat_n = cur_len;
          wr_n = 1'b1;
          state_n = BURST;
        end
      BURST:
        if (pop) begin
          rem_n = rem - ONE;
          beat_n = beat - 1'b1;
          if (beat == BURST_WIDTH_W'(1)) begin
            addr_n = addr + (ADD_WIDTH'(bc) << BE_SHIFT);
            if (rem == ONE) begin
              wr_n = 1'b0;
              done_n = 1'b1;
              state_n = IDLE;
            end else if (occ - ONE >= LEN_WIDTH'(nxt_len)) begin
              bc_n = nxt_len;
              beat_n = nxt_len;
            end else begin
              wr_n = 1'b0;
              state_n = WAIT_DATA;
            end
          end
        end
      default: ;
    endcase
  end
endmodule

// File: doc/ram_w_burst.md
RAM_W_BURST -- requirements
Module: ram_w_burst

Interface
REQ-001 SHALL have parameters: DATA_WIDTH 32, write data width; ADD_WIDTH 32, byte address width; BYTE_ENABLE_WIDTH DATA_WIDTH/8, bytes per word; MAX_BURST_COUNT_W 32, burst length in words (power of two); BURST_WIDTH_W 6, burstcount width (holds MAX_BURST_COUNT_W); FIFO_DEPTH_LOG2 8, log2 of buffer depth; LEN_WIDTH 24, job length width.
REQ-002 SHALL have ports: clk in 1, sole clock; rst in 1, asynchronous active-low reset; ram_w_address out ADD_WIDTH, burst byte address; ram_w_waitrequest in 1, slave stall; ram_w_byteenable out BYTE_ENABLE_WIDTH, byte lanes; ram_w_write out 1, write request; ram_w_writedata out DATA_WIDTH, beat data; ram_w_burstcount out BURST_WIDTH_W, beats in current burst.
REQ-003 SHALL have ports: data_fifo_out in DATA_WIDTH, push data; data_valid_fifo_out in 1, push strobe; start_fifo_out in 1, job start/flush; address_fifo_out in ADD_WIDTH, job base address; n_words_fifo_out in LEN_WIDTH, job length in words; bussy_fifo_out out 1, job active; full_fifo_out out 1, buffer full; usedw_fifo_out out FIFO_DEPTH_LOG2+1, buffer occupancy; done_fifo_out out 1, one-cycle job-complete pulse.

Function
REQ-004 SHALL contain an internal show-ahead buffer of 2^FIFO_DEPTH_LOG2 words; ram_w_writedata is the head word, combinationally valid whenever occupancy > 0.
REQ-005 SHALL accept a push when data_valid_fifo_out=1 and (occupancy < depth or a pop occurs that cycle); otherwise the word is dropped.
REQ-006 SHALL assert full_fifo_out when occupancy equals 2^FIFO_DEPTH_LOG2; usedw_fifo_out equals occupancy.
REQ-007 SHALL implement states IDLE, WAIT_DATA, BURST.
REQ-008 start_fifo_out=1 in any state SHALL, next edge: flush buffer (push that cycle discarded), load address, load remaining from n_words_fifo_out, deassert ram_w_write; go WAIT_DATA if remaining != 0, else IDLE with done_fifo_out pulsed next cycle.
REQ-009 WAIT_DATA: next burst length L = min(MAX_BURST_COUNT_W, remaining); when occupancy >= L, SHALL latch burstcount=L, assert ram_w_write next edge, enter BURST.
REQ-010 BURST: a beat is accepted when ram_w_write=1 and ram_w_waitrequest=0; each accepted beat SHALL pop one word, decrement beat counter and remaining.
REQ-011 ram_w_address, ram_w_burstcount SHALL be stable for the whole burst; writedata stable while waitrequest=1.
REQ-012 On last accepted beat, address SHALL advance by L*BYTE_ENABLE_WIDTH; if remaining becomes 0: ram_w_write=0, IDLE, done_fifo_out=1 for one cycle; else if occupancy-1 >= next L: stay BURST back-to-back with new burstcount, no idle cycle; else WAIT_DATA with ram_w_write=0.
REQ-013 Address SHALL wrap modulo 2^ADD_WIDTH.
REQ-014 bussy_fifo_out SHALL equal (remaining != 0); ram_w_byteenable SHALL be all ones.
REQ-015 start mid-burst aborts the burst (software responsibility); no done pulse for aborted job.

Reset
REQ-016 rst=0 SHALL immediately force: ram_w_write 0, ram_w_address 0, ram_w_burstcount 0, occupancy 0, remaining 0, done_fifo_out 0, bussy_fifo_out 0, state IDLE; full_fifo_out 0, usedw_fifo_out 0.

Configuration
REQ-017 With RAM_W_PARTIAL_BURST_EN defined, final burst SHALL be shortened to remaining words (L < MAX_BURST_COUNT_W allowed).
REQ-018 Without RAM_W_PARTIAL_BURST_EN, remaining SHALL load as n_words_fifo_out rounded down to a multiple of MAX_BURST_COUNT_W; ram_w_burstcount always MAX_BURST_COUNT_W; leftover words stay buffered until next start.

Verification
REQ-019 start, address 0x1000, n_words 64, push 64 words, waitrequest 0 -> bursts of 32 at 0x1000 and 0x1080, data in order, one done pulse, bussy low after.
REQ-020 n_words 40 -> with macro: bursts 32 @0x1000 and 8 @0x1080; without: one burst 32, done, usedw_fifo_out 8.
REQ-021 waitrequest high 5 cycles mid-burst -> address, burstcount, writedata unchanged, usedw unchanged, then burst resumes.
REQ-022 waitrequest high, 257 pushes -> usedw_fifo_out 256, full_fifo_out 1, word 257 not written.
REQ-023 start during beat 10 of a burst -> ram_w_write 0 next cycle, usedw 0, new address loaded, no done pulse.
REQ-024 rst low mid-burst, no clock edge -> ram_w_write 0, usedw_fifo_out 0 immediately.
